// File: rtl/tile_serializer_pkg.sv
// Shared widths and FSM encoding for the tile serializer slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tile_serializer_pkg;

   localparam int ELEM_W         = 16;
   localparam int TILE_OUT_ELEMS = 256;
   localparam int SER_LANES      = 16;

   typedef enum logic {
      SER_IDLE = 1'b0,
      SER_SEND = 1'b1
   } ser_state_t;

endpackage

// File: rtl/tile_beat_mux.sv
// Selects beat i_beat out of the captured vector and masks lanes beyond the valid count.
// Latency: purely combinational.
// Backpressure: none; outputs follow the (registered) inputs.
module tile_beat_mux
   import tile_serializer_pkg::*;
#(
   parameter int IN_ELEMS = TILE_OUT_ELEMS,
   parameter int DATA_W   = ELEM_W,
   parameter int LANES    = SER_LANES,
   parameter int CNT_W    = $clog2(IN_ELEMS + 1),
   parameter int BEAT_W   = $clog2(IN_ELEMS / LANES)
) (
   input  logic [IN_ELEMS*DATA_W-1:0] i_buf,
   input  logic [CNT_W-1:0]           i_cnt,
   input  logic [BEAT_W-1:0]          i_beat,
   output logic [LANES*DATA_W-1:0]    o_data,
   output logic [LANES-1:0]           o_mask
);

   localparam int NBEATS    = IN_ELEMS / LANES;
   localparam int BEAT_BITS = LANES * DATA_W;

   logic [BEAT_BITS-1:0] w_slice;
   logic [CNT_W-1:0]     w_idx;

   // Constant-index one-hot select of the beat slice keeps index widths exact.
   always_comb begin
      w_slice = '0;
      for (int b = 0; b < NBEATS; b++) begin
         if (i_beat == BEAT_W'(b)) begin
            w_slice = i_buf[b*BEAT_BITS +: BEAT_BITS];
         end
      end
   end

   // Lane valid when its absolute element index is below the count; invalid lanes read as zero.
   always_comb begin
      o_data = '0;
      o_mask = '0;
      w_idx  = '0;
      for (int l = 0; l < LANES; l++) begin
         w_idx = CNT_W'(i_beat) * CNT_W'(LANES) + CNT_W'(l);
         if (w_idx < i_cnt) begin
            o_mask[l]                   = 1'b1;
            o_data[l*DATA_W +: DATA_W]  = w_slice[l*DATA_W +: DATA_W];
         end
      end
   end

endmodule

// File: rtl/tile_serializer.sv
// Captures one tiled vector with its element count and streams it LANES elements per beat.
// Latency: capture at edge k gives out_valid from edge k+1; one idle cycle between vectors.
// Backpressure: out_ready low holds the current beat stable; no new vector accepted while sending.
module tile_serializer
   import tile_serializer_pkg::*;
#(
   parameter int IN_ELEMS = TILE_OUT_ELEMS,
   parameter int DATA_W   = ELEM_W,
   parameter int LANES    = SER_LANES,
   parameter int CNT_W    = $clog2(IN_ELEMS + 1),
   parameter int BEAT_W   = $clog2(IN_ELEMS / LANES)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [IN_ELEMS*DATA_W-1:0] in_data,
   input  logic [CNT_W-1:0]           in_count,
   input  logic                       in_valid,
   output logic                       in_ready,
   output logic [LANES*DATA_W-1:0]    out_data,
   output logic [LANES-1:0]           out_mask,
   output logic                       out_last,
   output logic                       out_valid,
   input  logic                       out_ready
);

   ser_state_t                 r_state;
   logic [IN_ELEMS*DATA_W-1:0] r_buf;
   logic [CNT_W-1:0]           r_cnt;
   logic [BEAT_W-1:0]          r_beat;
   logic [BEAT_W-1:0]          r_last_beat;
   logic                       r_in_rdy;
   logic                       r_out_vld;
   logic                       r_out_last;

   logic [CNT_W-1:0]           w_cnt_clamp;
   logic [CNT_W-1:0]           w_cnt_m1;
   logic [BEAT_W-1:0]          w_last_beat;
   logic [LANES*DATA_W-1:0]    w_beat_dat;
   logic [LANES-1:0]           w_beat_mask;

   // Oversized counts saturate at the vector size; last beat index is ceil(cnt/LANES)-1.
   assign w_cnt_clamp = (in_count > CNT_W'(IN_ELEMS)) ? CNT_W'(IN_ELEMS) : in_count;
   assign w_cnt_m1    = w_cnt_clamp - CNT_W'(1);
   assign w_last_beat = BEAT_W'(w_cnt_m1 / CNT_W'(LANES));

   // Capture/stream FSM; every handshake-visible output is a register here.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= SER_IDLE;
         r_buf       <= '0;
         r_cnt       <= '0;
         r_beat      <= '0;
         r_last_beat <= '0;
         r_in_rdy    <= 1'b1;
         r_out_vld   <= 1'b0;
         r_out_last  <= 1'b0;
      end else begin
         case (r_state)
            SER_IDLE: begin
               if (in_valid && r_in_rdy) begin
                  r_buf       <= in_data;
                  r_cnt       <= w_cnt_clamp;
                  r_beat      <= '0;
                  r_last_beat <= w_last_beat;
                  // A zero-count vector is consumed without producing any beat.
                  if (w_cnt_clamp != '0) begin
                     r_state    <= SER_SEND;
                     r_in_rdy   <= 1'b0;
                     r_out_vld  <= 1'b1;
                     r_out_last <= (w_last_beat == '0);
                  end
               end
            end
            SER_SEND: begin
               if (out_ready) begin
                  if (r_beat == r_last_beat) begin
                     r_state    <= SER_IDLE;
                     r_beat     <= '0;
                     r_in_rdy   <= 1'b1;
                     r_out_vld  <= 1'b0;
                     r_out_last <= 1'b0;
                  end else begin
                     r_beat     <= r_beat + BEAT_W'(1);
                     r_out_last <= ((r_beat + BEAT_W'(1)) == r_last_beat);
                  end
               end
            end
            default: r_state <= SER_IDLE;
         endcase
      end
   end

   tile_beat_mux #(
      .IN_ELEMS (IN_ELEMS),
      .DATA_W   (DATA_W),
      .LANES    (LANES),
      .CNT_W    (CNT_W),
      .BEAT_W   (BEAT_W)
   ) u_beat_mux (
      .i_buf  (r_buf),
      .i_cnt  (r_cnt),
      .i_beat (r_beat),
      .o_data (w_beat_dat),
      .o_mask (w_beat_mask)
   );

   // Beat payload is only presented while sending so idle outputs read as zero.
   assign in_ready  = r_in_rdy;
   assign out_valid = r_out_vld;
   assign out_last  = r_out_last;
   assign out_data  = r_out_vld ? w_beat_dat  : '0;
   assign out_mask  = r_out_vld ? w_beat_mask : '0;

endmodule

// File: tb/tb_tile_serializer.sv
// Self-checking bench: behavioural vector/beat model compared every cycle, plus literal pins.
// Latency: n/a.
// Backpressure: exercised with steady, patterned and random out_ready.
module tb_tile_serializer;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [4095:0] in_data;
   logic [8:0]    in_count;
   logic          in_valid;
   logic          in_ready;
   logic [255:0]  out_data;
   logic [15:0]   out_mask;
   logic          out_last;
   logic          out_valid;
   logic          out_ready;

   int n_vec = 0;
   int n_bad = 0;
   int cyc   = 0;
   bit chk_en = 1'b0;

   // reference model: captured vector and position in the frame
   bit m_busy   = 1'b0;
   int m_vec[256];
   int m_cnt    = 0;
   int m_beat   = 0;
   int m_nbeats = 0;

   // handshake log of what the DUT actually delivered
   logic [255:0] hs_data[$];
   logic [15:0]  hs_mask[$];
   bit           hs_last[$];
   int           hs_cyc[$];

   tile_serializer dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_count  (in_count),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_mask  (out_mask),
      .out_last  (out_last),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   // model update: frame-level rules, evaluated on each edge
   always @(posedge clk or posedge rst) begin
      cyc++;
      if (rst) begin
         m_busy = 1'b0;
         m_beat = 0;
      end else if (!m_busy) begin
         if (in_valid) begin
            m_cnt = (int'(in_count) > 256) ? 256 : int'(in_count);
            for (int e = 0; e < 256; e++) m_vec[e] = int'(in_data[e*16 +: 16]);
            m_beat   = 0;
            m_nbeats = (m_cnt + 15) / 16;
            m_busy   = (m_cnt > 0);
         end
      end else if (out_ready) begin
         if (m_beat == m_nbeats - 1) m_busy = 1'b0;
         else m_beat++;
      end
   end

   // compare process: every output, every cycle, on the falling edge
   always @(negedge clk) begin
      logic [255:0] exp_data;
      logic [15:0]  exp_mask;
      int e;
      if (chk_en) begin
         exp_data = '0;
         exp_mask = '0;
         if (m_busy) begin
            for (int l = 0; l < 16; l++) begin
               e = m_beat * 16 + l;
               if (e < m_cnt) begin
                  exp_mask[l]         = 1'b1;
                  exp_data[l*16 +: 16] = 16'(m_vec[e]);
               end
            end
         end
         chk("in_ready",  256'(in_ready),  256'(!m_busy));
         chk("out_valid", 256'(out_valid), 256'(m_busy));
         chk("out_last",  256'(out_last),  256'(m_busy && (m_beat == m_nbeats - 1)));
         chk("out_mask",  256'(out_mask),  256'(exp_mask));
         chk("out_data",  out_data,        exp_data);
         if (out_valid && out_ready) begin
            hs_data.push_back(out_data);
            hs_mask.push_back(out_mask);
            hs_last.push_back(out_last);
            hs_cyc.push_back(cyc);
         end
      end
   end

   task automatic hs_clear();
      hs_data.delete();
      hs_mask.delete();
      hs_last.delete();
      hs_cyc.delete();
   endtask

   task automatic accept_vec(input int cnt, input bit ramp);
      int  n;
      bit  acc;
      for (int e = 0; e < 256; e++) in_data[e*16 +: 16] = ramp ? 16'(e) : 16'($urandom);
      in_count = 9'(cnt);
      in_valid = 1'b1;
      n   = 0;
      acc = 1'b0;
      while (!acc && n < 50) begin
         acc = in_ready;
         cycle();
         n++;
      end
      if (!acc) begin
         n_vec++;
         n_bad++;
         $display("FAIL accept_timeout: got in_ready=0 for %0d cycles expected acceptance", n);
      end
   endtask

   // mode 0: always ready, 1: ready pattern 1,0,0 repeating, 2: random
   task automatic drain(input int mode);
      int n;
      n = 0;
      while (m_busy && n < 400) begin
         case (mode)
            0:       out_ready = 1'b1;
            1:       out_ready = (n % 3 == 0);
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
         cycle();
         n++;
      end
      if (m_busy) begin
         n_vec++;
         n_bad++;
         $display("FAIL drain_timeout: got frame still open after %0d cycles expected it done", n);
      end
      in_valid = 1'b0;
   endtask

   task automatic present(input int cnt, input bit ramp, input int mode, input bit hold);
      accept_vec(cnt, ramp);
      if (hold) begin
         for (int e = 0; e < 256; e++) in_data[e*16 +: 16] = 16'($urandom);
         in_count = 9'd5;
      end else begin
         in_valid = 1'b0;
      end
      drain(mode);
   endtask

   initial begin
      logic [15:0] mand;
      int nlast;
      int n;
      in_valid  = 1'b0;
      in_count  = '0;
      in_data   = '0;
      out_ready = 1'b0;
      #1 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready",  256'(in_ready),  256'(1));
      chk("rst_out_valid", 256'(out_valid), 256'(0));
      chk("rst_out_last",  256'(out_last),  256'(0));
      chk("rst_out_mask",  256'(out_mask),  256'(0));
      chk("rst_out_data",  out_data,        256'(0));
      rst    = 1'b0;
      chk_en = 1'b1;
      cycle();

      // full vector, ramp data, continuous ready
      hs_clear();
      present(256, 1'b1, 0, 1'b0);
      chk("t1_beats", 256'(hs_data.size()), 256'(16));
      if (hs_data.size() == 16) begin
         mand  = 16'hFFFF;
         nlast = 0;
         foreach (hs_mask[i]) mand &= hs_mask[i];
         foreach (hs_last[i]) nlast += int'(hs_last[i]);
         chk("t1_masks",      256'(mand),                   256'(16'hFFFF));
         chk("t1_nlast",      256'(nlast),                  256'(1));
         chk("t1_last15",     256'(hs_last[15]),            256'(1));
         chk("t1_b3_l5",      256'(hs_data[3][5*16 +: 16]), 256'(53));
         chk("t1_b15_l15",    256'(hs_data[15][255:240]),   256'(255));
         chk("t1_back2back",  256'(hs_cyc[15] - hs_cyc[0]), 256'(15));
      end

      // partial final beat
      hs_clear();
      present(40, 1'b1, 0, 1'b0);
      chk("t2_ready_after", 256'(in_ready), 256'(1));
      chk("t2_beats", 256'(hs_data.size()), 256'(3));
      if (hs_data.size() == 3) begin
         chk("t2_mask0", 256'(hs_mask[0]),           256'(16'hFFFF));
         chk("t2_mask2", 256'(hs_mask[2]),           256'(16'h00FF));
         chk("t2_b2_l0", 256'(hs_data[2][15:0]),     256'(32));
         chk("t2_b2_hi", 256'(hs_data[2][255:128]),  256'(0));
         chk("t2_last2", 256'(hs_last[2]),           256'(1));
      end

      // stalled consumer
      hs_clear();
      present(64, 1'b1, 1, 1'b0);
      chk("t3_beats", 256'(hs_data.size()), 256'(4));
      if (hs_data.size() == 4) begin
         for (int b = 0; b < 4; b++) chk("t3_beat_l0", 256'(hs_data[b][15:0]), 256'(b * 16));
      end

      // empty vector then a single beat
      hs_clear();
      present(0, 1'b1, 0, 1'b0);
      chk("t4_zero_beats", 256'(hs_data.size()), 256'(0));
      present(16, 1'b1, 0, 1'b0);
      chk("t4_beats", 256'(hs_data.size()), 256'(1));
      if (hs_data.size() == 1) begin
         chk("t4_mask", 256'(hs_mask[0]), 256'(16'hFFFF));
         chk("t4_last", 256'(hs_last[0]), 256'(1));
      end

      // asynchronous reset mid-frame
      hs_clear();
      out_ready = 1'b1;
      accept_vec(256, 1'b1);
      in_valid = 1'b0;
      n = 0;
      while (hs_data.size() < 6 && n < 50) begin
         cycle();
         n++;
      end
      #2 rst = 1'b1;
      #1;
      chk("t5_out_valid", 256'(out_valid), 256'(0));
      chk("t5_in_ready",  256'(in_ready),  256'(1));
      chk("t5_out_mask",  256'(out_mask),  256'(0));
      cycle();
      cycle();
      rst = 1'b0;
      repeat (20) cycle();
      chk("t5_beats", 256'(hs_data.size()), 256'(6));

      // clamped count, second vector held valid during SEND
      hs_clear();
      present(300, 1'b0, 0, 1'b1);
      chk("t6_beats", 256'(hs_data.size()), 256'(16));
      mand = 16'hFFFF;
      foreach (hs_mask[i]) mand &= hs_mask[i];
      chk("t6_masks", 256'(mand), 256'(16'hFFFF));

      // randomized traffic
      for (int v = 0; v < 80; v++) begin
         out_ready = 1'($urandom_range(0, 1));
         repeat ($urandom_range(0, 3)) cycle();
         present(int'($urandom_range(0, 511)), 1'b0, 2, 1'($urandom_range(0, 1)));
      end
      repeat (3) cycle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
